// File: rtl/mpu_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mpu_pkg : controller state encoding and index-width helpers for the MPU
//           memory/RF transfer sequencer.
// Rev 1.0
// ============================================================================
package mpu_pkg;

  localparam int DEF_M = 4;
  localparam int DEF_N = 4;
  localparam int MBITS = $clog2(DEF_M);
  localparam int NBITS = $clog2(DEF_N);

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t S_IDLE    = 3'd0;
  localparam ctrl_state_t S_LD_RUN  = 3'd1;
  localparam ctrl_state_t S_LD_DONE = 3'd2;
  localparam ctrl_state_t S_ST_SIZE = 3'd3;
  localparam ctrl_state_t S_ST_RUN  = 3'd4;
  localparam ctrl_state_t S_ST_DONE = 3'd5;

  // One extra bit so a dimension equal to a power of two is representable.
  function automatic int idx_w(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// mpu_xfer_ctrl_if : memory-port and RF-port bundle of the transfer sequencer.
// Rev 1.0
// ============================================================================
interface mpu_xfer_ctrl_if
  import mpu_pkg::*;
#(
  parameter int FP              = 32,
  parameter int M               = DEF_M,
  parameter int N               = DEF_N,
  parameter int MATRIX_REG_SIZE = 3
);
  localparam int MW = idx_w(M);
  localparam int NW = idx_w(N);

  logic                       load_en;
  logic                       store_en;
  logic [FP-1:0]              mem_load_element;
  logic [MW-1:0]              mem_m_load_size;
  logic [NW-1:0]              mem_n_load_size;
  logic [MATRIX_REG_SIZE-1:0] mem_load_addr;
  logic [MATRIX_REG_SIZE-1:0] mem_store_addr;
  logic                       mem_load_ack;
  logic                       mem_load_error;
  logic                       mem_store_en;
  logic [FP-1:0]              mem_store_element;
  logic [MW-1:0]              mem_m_store_size;
  logic [NW-1:0]              mem_n_store_size;
  logic                       reg_load_en;
  logic [MATRIX_REG_SIZE-1:0] reg_load_addr;
  logic [FP-1:0]              reg_load_element;
  logic [MW-1:0]              reg_m_load_size;
  logic [NW-1:0]              reg_n_load_size;
  logic [MW-1:0]              reg_i_load_loc;
  logic [NW-1:0]              reg_j_load_loc;
  logic                       reg_store_en;
  logic [MATRIX_REG_SIZE-1:0] reg_store_addr;
  logic [MW-1:0]              reg_i_store_loc;
  logic [NW-1:0]              reg_j_store_loc;
  logic [FP-1:0]              reg_store_element;
  logic [MW-1:0]              reg_m_store_size;
  logic [NW-1:0]              reg_n_store_size;

  modport slave (
    input  load_en, store_en, mem_load_element, mem_m_load_size, mem_n_load_size,
           mem_load_addr, mem_store_addr, reg_store_element, reg_m_store_size,
           reg_n_store_size,
    output mem_load_ack, mem_load_error, mem_store_en, mem_store_element,
           mem_m_store_size, mem_n_store_size, reg_load_en, reg_load_addr,
           reg_load_element, reg_m_load_size, reg_n_load_size, reg_i_load_loc,
           reg_j_load_loc, reg_store_en, reg_store_addr, reg_i_store_loc,
           reg_j_store_loc
  );

  modport master (
    output load_en, store_en, mem_load_element, mem_m_load_size, mem_n_load_size,
           mem_load_addr, mem_store_addr, reg_store_element, reg_m_store_size,
           reg_n_store_size,
    input  mem_load_ack, mem_load_error, mem_store_en, mem_store_element,
           mem_m_store_size, mem_n_store_size, reg_load_en, reg_load_addr,
           reg_load_element, reg_m_load_size, reg_n_load_size, reg_i_load_loc,
           reg_j_load_loc, reg_store_en, reg_store_addr, reg_i_store_loc,
           reg_j_store_loc
  );

endinterface
`default_nettype wire

// File: rtl/mpu_xfer_ctrl_idx_counter.sv
`default_nettype none
// ============================================================================
// mpu_idx_counter : row-major (i,j) element counter over an m x n matrix.
// Rev 1.0
// ============================================================================
module mpu_idx_counter #(
  parameter int MW = 3,
  parameter int NW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [MW-1:0] m,
  input  logic [NW-1:0] n,
  output logic [MW-1:0] i,
  output logic [NW-1:0] j,
  output logic          last
);

  logic [MW-1:0] i_q, i_d;
  logic [NW-1:0] j_q, j_d;
  logic          i_wrap;
  logic          j_wrap;

  always_comb begin
    i_wrap = (i_q == m - MW'(1));
    j_wrap = (j_q == n - NW'(1));
    i_d    = i_q;
    j_d    = j_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
    end else if (inc) begin
      if (j_wrap) begin
        j_d = '0;
        i_d = i_wrap ? '0 : i_q + MW'(1);
      end else begin
        j_d = j_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign last = i_wrap & j_wrap;

endmodule
`default_nettype wire

// File: rtl/mpu_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// mpu_xfer_ctrl : paced LOAD (memory -> RF) and STORE (RF -> memory) sequencer
//                 with size checking and abort handling.
// Rev 1.0
// ============================================================================
module mpu_xfer_ctrl
  import mpu_pkg::*;
#(
  parameter int FP              = 32,
  parameter int M               = DEF_M,
  parameter int N               = DEF_N,
  parameter int MATRIX_REG_SIZE = 3,
  parameter int ELEM_STRIDE     = 2
) (
  input  logic             clk,
  input  logic             rst,
  mpu_xfer_ctrl_if.slave   bus
);

  localparam int MW = idx_w(M);
  localparam int NW = idx_w(N);
  localparam int SW = (ELEM_STRIDE > 1) ? $clog2(ELEM_STRIDE) : 1;
  localparam int DW = $clog2(ELEM_STRIDE + 1);
  localparam logic [SW-1:0] C_SLOT_LAST = SW'(ELEM_STRIDE - 1);
  localparam logic [MW-1:0] C_M_MAX     = MW'(M);
  localparam logic [NW-1:0] C_N_MAX     = NW'(N);
  localparam logic [DW-1:0] C_DRAIN     = DW'(ELEM_STRIDE);

  ctrl_state_t                state_q, state_d;
  logic [SW-1:0]              slot_q, slot_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic                       ld_we_q, ld_we_d;
  logic [MATRIX_REG_SIZE-1:0] ld_addr_q, ld_addr_d;
  logic [FP-1:0]              ld_elem_q, ld_elem_d;
  logic [MW-1:0]              ld_m_q, ld_m_d;
  logic [NW-1:0]              ld_n_q, ld_n_d;
  logic [MW-1:0]              ld_iloc_q, ld_iloc_d;
  logic [NW-1:0]              ld_jloc_q, ld_jloc_d;
  logic [MATRIX_REG_SIZE-1:0] st_addr_q, st_addr_d;
  logic                       st_en_q, st_en_d;
  logic [FP-1:0]              st_elem_q, st_elem_d;
  logic [MW-1:0]              st_m_q, st_m_d;
  logic [NW-1:0]              st_n_q, st_n_d;
  logic                       rd_pend_q, rd_pend_d;
  logic                       rd_last_q, rd_last_d;
  logic                       issued_q, issued_d;
  logic [DW-1:0]              drain_q, drain_d;

  logic                       ld_clr, ld_inc, st_clr, st_inc, rd_strobe;
  logic [MW-1:0]              ld_i, st_i;
  logic [NW-1:0]              ld_j, st_j;
  logic                       ld_last, st_last;
  logic                       size_ok;

  mpu_idx_counter #(.MW(MW), .NW(NW)) u_ld_idx (
    .clk (clk), .rst (rst), .clr (ld_clr), .inc (ld_inc),
    .m (ld_m_q), .n (ld_n_q), .i (ld_i), .j (ld_j), .last (ld_last)
  );

  mpu_idx_counter #(.MW(MW), .NW(NW)) u_st_idx (
    .clk (clk), .rst (rst), .clr (st_clr), .inc (st_inc),
    .m (st_m_q), .n (st_n_q), .i (st_i), .j (st_j), .last (st_last)
  );

  assign size_ok = (bus.mem_m_load_size != '0) && (bus.mem_m_load_size <= C_M_MAX) &&
                   (bus.mem_n_load_size != '0) && (bus.mem_n_load_size <= C_N_MAX);

  always_comb begin
    state_d   = state_q;
    slot_d    = (slot_q == C_SLOT_LAST) ? '0 : slot_q + SW'(1);
    ack_d     = ack_q;
    err_d     = 1'b0;
    ld_we_d   = 1'b0;
    ld_addr_d = ld_addr_q;
    ld_elem_d = ld_elem_q;
    ld_m_d    = ld_m_q;
    ld_n_d    = ld_n_q;
    ld_iloc_d = ld_iloc_q;
    ld_jloc_d = ld_jloc_q;
    st_addr_d = st_addr_q;
    st_en_d   = st_en_q;
    st_elem_d = st_elem_q;
    st_m_d    = st_m_q;
    st_n_d    = st_n_q;
    rd_pend_d = 1'b0;
    rd_last_d = 1'b0;
    issued_d  = issued_q;
    drain_d   = drain_q;
    ld_clr    = 1'b0;
    ld_inc    = 1'b0;
    st_clr    = 1'b0;
    st_inc    = 1'b0;
    rd_strobe = 1'b0;

    case (state_q)
      S_IDLE: begin
        slot_d   = '0;
        ld_clr   = 1'b1;
        st_clr   = 1'b1;
        issued_d = 1'b0;
        drain_d  = '0;
        if (bus.load_en) begin
          if (size_ok) begin
            ld_m_d    = bus.mem_m_load_size;
            ld_n_d    = bus.mem_n_load_size;
            ld_addr_d = bus.mem_load_addr;
            ack_d     = 1'b1;
            state_d   = S_LD_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_LD_DONE;
          end
        end else if (bus.store_en) begin
          st_addr_d = bus.mem_store_addr;
          state_d   = S_ST_SIZE;
        end
      end

      S_LD_RUN: begin
        if (!bus.load_en) begin
          ack_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (slot_q == C_SLOT_LAST) begin
          ld_we_d   = 1'b1;
          ld_elem_d = bus.mem_load_element;
          ld_iloc_d = ld_i;
          ld_jloc_d = ld_j;
          ld_inc    = 1'b1;
          if (ld_last) begin
            ack_d   = 1'b0;
            state_d = S_LD_DONE;
          end
        end
      end

      S_LD_DONE: begin
        if (!bus.load_en) state_d = S_IDLE;
      end

      S_ST_SIZE: begin
        slot_d = '0;
        if (!bus.store_en) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          st_m_d = bus.reg_m_store_size;
          st_n_d = bus.reg_n_store_size;
          if ((bus.reg_m_store_size == '0) || (bus.reg_n_store_size == '0)) begin
            err_d   = 1'b1;
            state_d = S_ST_DONE;
          end else begin
            state_d = S_ST_RUN;
          end
        end
      end

      S_ST_RUN: begin
        if (!bus.store_en) begin
          err_d   = 1'b1;
          st_en_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          if ((slot_q == '0) && !issued_q) begin
            rd_strobe = 1'b1;
            st_inc    = 1'b1;
            rd_pend_d = 1'b1;
            rd_last_d = st_last;
            issued_d  = st_last;
          end
          // RF data arrives one cycle after the strobe; the last element is
          // then held for a full stride before the window closes.
          if (rd_pend_q) begin
            st_elem_d = bus.reg_store_element;
            st_en_d   = 1'b1;
            if (rd_last_q) drain_d = C_DRAIN;
          end else if (drain_q != '0) begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) begin
              st_en_d = 1'b0;
              state_d = S_ST_DONE;
            end
          end
        end
      end

      S_ST_DONE: begin
        if (!bus.store_en) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ld_we_q   <= 1'b0;
      ld_addr_q <= '0;
      ld_elem_q <= '0;
      ld_m_q    <= '0;
      ld_n_q    <= '0;
      ld_iloc_q <= '0;
      ld_jloc_q <= '0;
      st_addr_q <= '0;
      st_en_q   <= 1'b0;
      st_elem_q <= '0;
      st_m_q    <= '0;
      st_n_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      issued_q  <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      ld_we_q   <= ld_we_d;
      ld_addr_q <= ld_addr_d;
      ld_elem_q <= ld_elem_d;
      ld_m_q    <= ld_m_d;
      ld_n_q    <= ld_n_d;
      ld_iloc_q <= ld_iloc_d;
      ld_jloc_q <= ld_jloc_d;
      st_addr_q <= st_addr_d;
      st_en_q   <= st_en_d;
      st_elem_q <= st_elem_d;
      st_m_q    <= st_m_d;
      st_n_q    <= st_n_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      issued_q  <= issued_d;
      drain_q   <= drain_d;
    end
  end

  assign bus.mem_load_ack      = ack_q;
  assign bus.mem_load_error    = err_q;
  assign bus.mem_store_en      = st_en_q;
  assign bus.mem_store_element = st_elem_q;
  assign bus.mem_m_store_size  = st_m_q;
  assign bus.mem_n_store_size  = st_n_q;
  assign bus.reg_load_en       = ld_we_q;
  assign bus.reg_load_addr     = ld_addr_q;
  assign bus.reg_load_element  = ld_elem_q;
  assign bus.reg_m_load_size   = ld_m_q;
  assign bus.reg_n_load_size   = ld_n_q;
  assign bus.reg_i_load_loc    = ld_iloc_q;
  assign bus.reg_j_load_loc    = ld_jloc_q;
  assign bus.reg_store_en      = rd_strobe;
  assign bus.reg_store_addr    = st_addr_q;
  assign bus.reg_i_store_loc   = st_i;
  assign bus.reg_j_store_loc   = st_j;

endmodule
`default_nettype wire
